// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_pkg
//  Purpose  : Shared constants for the seven-segment scanner: segment bit
//             positions and the hex-to-segment font table (active-high).
//  Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Entry [n] is the a..g pattern for hex digit n; listed F down to 0.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage
`default_nettype wire

// File: rtl/hex7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : hex7_decode
//  Purpose  : Combinational hex nibble to active-high a..g segment decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module hex7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX7_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan
//  Purpose  : Multiplexed seven-segment scanner with frame-synchronous
//             double-buffered display data and an anti-ghost blank window.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int TICK_W = $clog2(REFRESH_DIV);

    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0]     BLANK_END = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_BASE   = NUM_DIGITS'(1);
    localparam logic                  INV       = (ACTIVE_LOW != 0);

    logic [TICK_W-1:0]       r_tick;
    logic [IDX_W-1:0]        r_idx;

    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en;
    logic [4*NUM_DIGITS-1:0] r_act_value;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [NUM_DIGITS-1:0]   r_act_en;

    logic                    w_tick_last;
    logic                    w_wrap;
    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic [6:0]              w_segs;
    logic [NUM_DIGITS-1:0]   w_an;

    assign w_tick_last = (r_tick == TICK_LAST);
    assign w_wrap      = w_tick_last && (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
            r_idx  <= '0;
        end else begin
            r_tick <= w_tick_last ? '0 : r_tick + 1'b1;
            if (w_tick_last) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Active copy only changes at the frame wrap; a load on that same edge
    // bypasses the pending buffer so it is not delayed by a whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
        end else begin
            if (load) begin
                r_pend_value <= value;
                r_pend_dp    <= dp_in;
                r_pend_en    <= digit_en;
            end
            if (w_wrap) begin
                r_act_value <= load ? value    : r_pend_value;
                r_act_dp    <= load ? dp_in    : r_pend_dp;
                r_act_en    <= load ? digit_en : r_pend_en;
            end
        end
    end

    assign w_nibble = r_act_value[{r_idx, 2'b00} +: 4];
    assign w_lit    = (r_tick >= BLANK_END) && r_act_en[r_idx];
    assign w_an     = w_lit ? (AN_BASE << r_idx) : '0;

    hex7_decode u_decode (
        .nibble (w_nibble),
        .segs   (w_segs)
    );

    // Polarity is applied only here so all internal logic stays active-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= {NUM_DIGITS{INV}};
            seg        <= {7{INV}};
            dp         <= INV;
            frame_done <= 1'b0;
        end else begin
            an         <= w_an ^ {NUM_DIGITS{INV}};
            seg        <= (w_lit ? w_segs : 7'd0) ^ {7{INV}};
            dp         <= (w_lit && r_act_dp[r_idx]) ^ INV;
            frame_done <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan
//  Purpose  : Self-checking bench for seven_seg_scan (4 digits, 8-cycle slots,
//             2-cycle blank window, active-low outputs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    // Font written straight from the segment list, active-high a..g.
    logic [6:0] font [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: t counts clock edges since reset release.
    int          t;
    logic [15:0] p_val, a_val;
    logic [3:0]  p_dp, a_dp, p_en, a_en;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;
    bit          model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    task automatic cyc();
        int  tick;
        int  idx;
        bit  lit;
        @(posedge clk);
        if (rst) begin
            t       = 0;
            p_val   = '0; p_dp = '0; p_en = '0;
            a_val   = '0; a_dp = '0; a_en = '0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_fd  = 1'b0;
        end else begin
            tick    = t % DIV;
            idx     = (t / DIV) % N;
            lit     = (tick >= BLANK) && a_en[idx];
            exp_an  = lit ? ~(4'b0001 << idx) : 4'hF;
            exp_seg = lit ? ~font[a_val[idx*4 +: 4]] : 7'h7F;
            exp_dp  = lit ? ~a_dp[idx] : 1'b1;
            exp_fd  = (t % FRAME) == FRAME - 1;
            if (exp_fd) begin
                if (load) begin
                    a_val = value; a_dp = dp_in; a_en = digit_en;
                end else begin
                    a_val = p_val; a_dp = p_dp; a_en = p_en;
                end
            end
            if (load) begin
                p_val = value; p_dp = dp_in; p_en = digit_en;
            end
            t++;
        end
        model_valid = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            check("an", {28'd0, an}, {28'd0, exp_an});
            check("seg", {25'd0, seg}, {25'd0, exp_seg});
            check("dp", {31'd0, dp}, {31'd0, exp_dp});
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 3 * FRAME; i++) begin
            cyc();
            if (frame_done) return;
        end
        timeout_fail("wait_frame");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Called just after a negedge; asserts reset mid-cycle and checks that
    // the outputs drop to inactive without waiting for a clock edge.
    task automatic mid_reset(input int hold);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_fd", {31'd0, frame_done}, 32'h0);
        run(hold);
        rst = 1'b0;
    endtask

    logic [3:0] scan_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};

    initial begin
        int k;
        int cnt_lit, cnt_bad, cnt_ghost, cnt_dp1, cnt_dp3;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
        run(3);
        rst = 1'b0;

        // Data loaded right after release goes live at the first wrap, then
        // digit 0 lights once its blank window has passed.
        do_load(16'h3210, 4'h0, 4'hF);
        k = 1;
        while (an == 4'hF && k < 3 * FRAME) begin
            cyc();
            k++;
        end
        check("first_lit_cycle", k, FRAME + BLANK + 1);
        check("first_lit_an", {28'd0, an}, 32'hE);

        wait_frame();
        k = 0;
        for (int i = 0; i < N; i++) begin
            while (k < i * DIV + 5) begin cyc(); k++; end
            check("scan_an", {28'd0, an}, {28'd0, scan_an[i]});
            check("scan_seg", {25'd0, seg}, {25'd0, scan_seg[i]});
        end
        wait_frame();
        k = 0;
        do begin cyc(); k++; end while (!frame_done && k < 3 * FRAME);
        check("frame_period", k, FRAME);

        // Tearing: a mid-frame load must not change the frame in progress.
        do_load(16'hAAAA, 4'h0, 4'hF);
        wait_frame();
        wait_frame();
        run(5);
        check("tear_first", {25'd0, seg}, 32'b0001000);
        do_load(16'h5555, 4'h0, 4'hF);
        k = 6;
        while (k < 2 * DIV + 5) begin cyc(); k++; end
        check("tear_hold", {25'd0, seg}, 32'b0001000);
        wait_frame();
        run(DIV + 5);
        check("tear_next_an", {28'd0, an}, 32'b1101);
        check("tear_next_seg", {25'd0, seg}, 32'b0100100);

        // Load presented on the wrap edge lands directly in the new frame.
        wait_frame();
        run(FRAME - 1);
        do_load(16'hFFFF, 4'h0, 4'hF);
        check("simul_fd", {31'd0, frame_done}, 32'h1);
        run(5);
        check("simul_seg", {25'd0, seg}, 32'b0111000);

        // Blanking and decimal point.
        do_load(16'h9876, 4'b0010, 4'b1010);
        wait_frame();
        wait_frame();
        cnt_lit = 0; cnt_bad = 0; cnt_ghost = 0; cnt_dp1 = 0; cnt_dp3 = 0;
        for (int j = 1; j <= FRAME; j++) begin
            cyc();
            if (an != 4'hF) cnt_lit++;
            if (!an[0] || !an[2]) cnt_bad++;
            if (((j - 1) % DIV) < BLANK && an != 4'hF) cnt_ghost++;
            if (an == 4'b1101 && !dp) cnt_dp1++;
            if (an == 4'b0111 && !dp) cnt_dp3++;
        end
        check("blank_lit_count", cnt_lit, 2 * (DIV - BLANK));
        check("blank_disabled_lit", cnt_bad, 0);
        check("blank_window_lit", cnt_ghost, 0);
        check("dp_digit1", cnt_dp1, DIV - BLANK);
        check("dp_digit3", cnt_dp3, 0);

        // Reset mid-slot with a load pending: it must be discarded.
        run(11);
        do_load(16'h1111, 4'hF, 4'hF);
        mid_reset(2);
        run(2 * FRAME + 4);

        // Randomised traffic with occasional mid-frame resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                mid_reset($urandom_range(1, 3));
            end else if ($urandom_range(0, 9) == 0) begin
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
